// File: rtl/coherence_hub_if.sv
// Cache-side bus of the coherence hub: snooped write requests in, invalidates and status out.
// Carries every per-channel signal as a flat vector; channel i sits at slice i.
interface coherence_hub_if #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8
);
    localparam int REQ_W = 1 + ADDR_W + DATA_W;

    logic [CHANNELS*REQ_W-1:0]  cache_change;
    logic [CHANNELS-1:0]        cache_change_valid;
    logic [CHANNELS*ADDR_W-1:0] cache_invalidate;
    logic [CHANNELS-1:0]        cache_invalidate_valid;
    logic [CHANNELS-1:0]        cache_invalidate_ack;
    logic [CHANNELS-1:0]        queue_full;
    logic [CHANNELS-1:0]        overflow;
    logic                       busy;

    modport master (
        output cache_change, cache_change_valid, cache_invalidate_ack,
        input  cache_invalidate, cache_invalidate_valid, queue_full, overflow, busy
    );

    modport slave (
        input  cache_change, cache_change_valid, cache_invalidate_ack,
        output cache_invalidate, cache_invalidate_valid, queue_full, overflow, busy
    );
endinterface

// File: rtl/coherence_hub.sv
// Coherence hub: queues snooped cache writes per channel and broadcasts an invalidate
// of each written address to all other caches, arbitrating round-robin between channels.
module coherence_hub #(
    parameter int CHANNELS   = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic            clock,
    input logic            reset,
    coherence_hub_if.slave bus
);
    localparam int REQ_W = 1 + ADDR_W + DATA_W;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int GW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, BCAST} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   mem [CHANNELS][FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr [CHANNELS];
    logic [PW-1:0]       rd_ptr [CHANNELS];
    logic [CW-1:0]       count [CHANNELS];
    logic [CW-1:0]       count_nxt [CHANNELS];
    logic [CHANNELS-1:0] push_req, push_ok, nonempty, pop;
    logic [CHANNELS-1:0] pending, pending_nxt, overflow_q, full_q;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [GW-1:0]       last_grant, grant_idx, cand;
    logic                grant_found, do_grant;
    logic                unused_bits;

    // Data bits and read requests are snooped but never stored.
    assign unused_bits = ^bus.cache_change;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            push_req[i] = bus.cache_change_valid[i] & bus.cache_change[i*REQ_W + REQ_W-1];
            nonempty[i] = (count[i] != '0);
            push_ok[i]  = push_req[i] & (count[i] != CW'(FIFO_DEPTH));
        end
    end

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = GW'((int'(last_grant) + k) % CHANNELS);
            if (!grant_found && nonempty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        do_grant    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) do_grant = 1'b1;
            end
            BCAST: begin
                pending_nxt = pending & ~bus.cache_invalidate_ack;
                if (pending_nxt == '0) begin
                    if (grant_found) do_grant  = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // With a single channel the target mask is empty, so a grant never leaves IDLE.
        if (do_grant) begin
            pending_nxt = ~(CHANNELS'(1) << grant_idx);
            state_nxt   = (pending_nxt != '0) ? BCAST : IDLE;
        end
        pop      = do_grant ? (CHANNELS'(1) << grant_idx) : '0;
        addr_nxt = mem[grant_idx][rd_ptr[grant_idx]];
        for (int i = 0; i < CHANNELS; i++)
            count_nxt[i] = count[i] + CW'(push_ok[i]) - CW'(pop[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            last_grant <= GW'(CHANNELS - 1);
            addr_q     <= '0;
            overflow_q <= '0;
            full_q     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (do_grant) begin
                last_grant <= grant_idx;
                addr_q     <= addr_nxt;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (push_req[i] && !push_ok[i]) overflow_q[i] <= 1'b1;
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])     rd_ptr[i] <= rd_ptr[i] + PW'(1);
                count[i]  <= count_nxt[i];
                full_q[i] <= (count_nxt[i] == CW'(FIFO_DEPTH));
            end
        end
    end

    // Queue storage carries no reset; the counts alone say what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++)
            if (push_ok[i])
                mem[i][wr_ptr[i]] <= bus.cache_change[i*REQ_W + DATA_W +: ADDR_W];
    end

    assign bus.cache_invalidate       = {CHANNELS{addr_q}};
    assign bus.cache_invalidate_valid = pending;
    assign bus.overflow               = overflow_q;
    assign bus.queue_full             = full_q;
    assign bus.busy                   = (state == BCAST);
endmodule

// File: tb/tb_coherence_hub.sv
// Bench for coherence_hub: a 2-channel and a 4-channel hub, directed stimulus, a queue-based
// reference model compared every cycle, and hand-computed expectations at key points.
module tb_coherence_hub;
    localparam int RW = 25;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    coherence_hub_if #(.CHANNELS(2), .ADDR_W(16), .DATA_W(8)) bus2 ();
    coherence_hub_if #(.CHANNELS(4), .ADDR_W(16), .DATA_W(8)) bus4 ();

    coherence_hub #(.CHANNELS(2), .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4)) dut2 (
        .clock(clk), .reset(reset), .bus(bus2));
    coherence_hub #(.CHANNELS(4), .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4)) dut4 (
        .clock(clk), .reset(reset), .bus(bus4));

    // Reference model: index 0 is the 2-channel hub, index 1 the 4-channel hub.
    logic [15:0] mq [2][4][$];
    logic [3:0]  m_pend [2];
    int          m_lg [2];
    bit          m_busy [2];
    logic [15:0] m_addr [2];
    logic [3:0]  m_ovf [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int m, input int n, input bit rst, input logic [3:0] vld,
                              input logic [3:0] wr, input logic [63:0] a, input logic [3:0] ack);
        int sz [4];
        int gr;
        int c;
        logic [3:0] left;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[m][i].delete();
            m_pend[m] = '0; m_lg[m] = n - 1; m_busy[m] = 0; m_addr[m] = '0; m_ovf[m] = '0;
            return;
        end
        for (int i = 0; i < 4; i++) sz[i] = mq[m][i].size();
        gr = -1;
        left = m_pend[m] & ~ack;
        if (!m_busy[m] || left == 0)
            for (int k = 1; k <= n; k++) begin
                c = (m_lg[m] + k) % n;
                if (gr < 0 && sz[c] > 0) gr = c;
            end
        if (m_busy[m]) m_pend[m] = left;
        if (gr >= 0) begin
            m_addr[m] = mq[m][gr].pop_front();
            m_pend[m] = 4'((1 << n) - 1) & ~(4'b1 << gr);
            m_lg[m]   = gr;
            m_busy[m] = (m_pend[m] != 0);
        end else if (m_busy[m] && m_pend[m] == 0) begin
            m_busy[m] = 0;
        end
        for (int i = 0; i < n; i++)
            if (vld[i] && wr[i]) begin
                if (sz[i] >= 4) m_ovf[m][i] = 1'b1;
                else            mq[m][i].push_back(a[i*16 +: 16]);
            end
    endtask

    function automatic logic [3:0] model_full(input int m);
        logic [3:0] f;
        f = '0;
        for (int i = 0; i < 4; i++) f[i] = (mq[m][i].size() == 4);
        return f;
    endfunction

    logic [3:0]  s_w2, s_w4;
    logic [63:0] s_a2, s_a4;

    always begin
        @(posedge clk);
        s_w2 = '0; s_w4 = '0; s_a2 = '0; s_a4 = '0;
        for (int i = 0; i < 2; i++) begin
            s_w2[i] = bus2.cache_change[i*RW + 24];
            s_a2[i*16 +: 16] = bus2.cache_change[i*RW + 8 +: 16];
        end
        for (int i = 0; i < 4; i++) begin
            s_w4[i] = bus4.cache_change[i*RW + 24];
            s_a4[i*16 +: 16] = bus4.cache_change[i*RW + 8 +: 16];
        end
        model_step(0, 2, reset, {2'b00, bus2.cache_change_valid}, s_w2, s_a2,
                   {2'b00, bus2.cache_invalidate_ack});
        model_step(1, 4, reset, bus4.cache_change_valid, s_w4, s_a4, bus4.cache_invalidate_ack);
        #1;
        check("m2_valid", 64'(bus2.cache_invalidate_valid), 64'(m_pend[0][1:0]));
        check("m2_addr",  64'(bus2.cache_invalidate), 64'({m_addr[0], m_addr[0]}));
        check("m2_busy",  64'(bus2.busy), 64'(m_busy[0]));
        check("m2_full",  64'(bus2.queue_full), 64'(model_full(0) & 4'b0011));
        check("m2_ovf",   64'(bus2.overflow), 64'(m_ovf[0][1:0]));
        check("m4_valid", 64'(bus4.cache_invalidate_valid), 64'(m_pend[1]));
        check("m4_addr",  bus4.cache_invalidate, {4{m_addr[1]}});
        check("m4_busy",  64'(bus4.busy), 64'(m_busy[1]));
        check("m4_full",  64'(bus4.queue_full), 64'(model_full(1)));
        check("m4_ovf",   64'(bus4.overflow), 64'(m_ovf[1]));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr2(input int ch, input logic w, input logic [15:0] a);
        bus2.cache_change[ch*RW +: RW] = {w, a, 8'h5A};
        bus2.cache_change_valid[ch] = 1'b1;
    endtask

    task automatic clr2();
        bus2.cache_change = '0;
        bus2.cache_change_valid = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [3:0] exp4 [8];
    int cnt;

    initial begin
        bus2.cache_change = '0; bus2.cache_change_valid = '0; bus2.cache_invalidate_ack = '0;
        bus4.cache_change = '0; bus4.cache_change_valid = '0; bus4.cache_invalidate_ack = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        check("rst_valid", 64'(bus2.cache_invalidate_valid), 64'd0);
        check("rst_addr",  64'(bus2.cache_invalidate), 64'd0);
        check("rst_busy",  64'(bus2.busy), 64'd0);
        check("rst_full",  64'(bus2.queue_full), 64'd0);
        check("rst_ovf",   64'(bus2.overflow), 64'd0);

        // Single write from channel 0.
        wr2(0, 1'b1, 16'h1234);
        step();
        clr2();
        check("single_idle", 64'(bus2.busy), 64'd0);
        bus2.cache_invalidate_ack = 2'b10;
        step();
        check("single_valid", 64'(bus2.cache_invalidate_valid), 64'h2);
        check("single_addr1", 64'(bus2.cache_invalidate[16 +: 16]), 64'h1234);
        check("single_busy",  64'(bus2.busy), 64'd1);
        step();
        check("single_done_valid", 64'(bus2.cache_invalidate_valid), 64'd0);
        check("single_done_busy",  64'(bus2.busy), 64'd0);
        bus2.cache_invalidate_ack = '0;

        // Reads are ignored.
        wr2(1, 1'b0, 16'hBEEF);
        step();
        clr2();
        step();
        check("read_busy",  64'(bus2.busy), 64'd0);
        check("read_valid", 64'(bus2.cache_invalidate_valid), 64'd0);

        // Round-robin: simultaneous writes granted 0 then 1 on back-to-back edges.
        pulse_reset();
        bus2.cache_invalidate_ack = 2'b11;
        wr2(0, 1'b1, 16'h0001);
        wr2(1, 1'b1, 16'h0002);
        step();
        clr2();
        step();
        check("rr_first_valid", 64'(bus2.cache_invalidate_valid), 64'h2);
        check("rr_first_addr",  64'(bus2.cache_invalidate[16 +: 16]), 64'h0001);
        step();
        check("rr_second_valid", 64'(bus2.cache_invalidate_valid), 64'h1);
        check("rr_second_addr",  64'(bus2.cache_invalidate[0 +: 16]), 64'h0002);
        step();
        check("rr_end_busy", 64'(bus2.busy), 64'd0);
        bus2.cache_invalidate_ack = '0;

        // Staggered acks on the 4-channel hub.
        exp4[1] = 4'b0000; exp4[2] = 4'b1011; exp4[3] = 4'b1010; exp4[4] = 4'b1010;
        exp4[5] = 4'b0010; exp4[6] = 4'b0000; exp4[7] = 4'b0000;
        bus4.cache_change[2*RW +: RW] = {1'b1, 16'h00AA, 8'h00};
        bus4.cache_change_valid = 4'b0100;
        for (int c = 1; c <= 7; c++) begin
            bus4.cache_invalidate_ack = (c == 3) ? 4'b0001 : (c == 5) ? 4'b1000 :
                                        (c == 6) ? 4'b0010 : 4'b0000;
            step();
            bus4.cache_change = '0;
            bus4.cache_change_valid = '0;
            check("stag_valid", 64'(bus4.cache_invalidate_valid), 64'(exp4[c]));
            check("stag_busy", 64'(bus4.busy), 64'((c >= 2 && c <= 5) ? 1 : 0));
            if (c == 2) check("stag_addr0", 64'(bus4.cache_invalidate[0 +: 16]), 64'h00AA);
        end
        bus4.cache_invalidate_ack = '0;

        // Overflow: six writes with acks low; one dropped, five broadcasts.
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            wr2(0, 1'b1, 16'h0100 + 16'(k));
            step();
        end
        clr2();
        check("ovf_full", 64'(bus2.queue_full[0]), 64'd1);
        check("ovf_flag", 64'(bus2.overflow[0]), 64'd1);
        bus2.cache_invalidate_ack = 2'b10;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus2.cache_invalidate_valid[1]) cnt++;
            step();
        end
        check("ovf_bcast_count", 64'(cnt), 64'd5);
        check("ovf_end_busy", 64'(bus2.busy), 64'd0);
        check("ovf_end_full", 64'(bus2.queue_full), 64'd0);
        check("ovf_sticky", 64'(bus2.overflow), 64'h1);
        bus2.cache_invalidate_ack = '0;

        // Reset in the middle of a broadcast with entries still queued.
        for (int k = 0; k < 3; k++) begin
            wr2(0, 1'b1, 16'h0200 + 16'(k));
            step();
        end
        clr2();
        check("mid_busy_before", 64'(bus2.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_valid", 64'(bus2.cache_invalidate_valid), 64'd0);
        check("mid_addr",  64'(bus2.cache_invalidate), 64'd0);
        check("mid_busy",  64'(bus2.busy), 64'd0);
        check("mid_full",  64'(bus2.queue_full), 64'd0);
        check("mid_ovf",   64'(bus2.overflow), 64'd0);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_busy",  64'(bus2.busy), 64'd0);
            check("post_valid", 64'(bus2.cache_invalidate_valid), 64'd0);
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/coherence_hub.md
# coherence_hub

Parametrised successor to the two-cache coherence unit. Snoops write requests from `CHANNELS` caches, queues them per channel, and arbitrates round-robin among channels. For each queued write it broadcasts an invalidate of the written address to every other cache, then waits until each target acknowledges. Sits beside the caches in the top level, tapping each cache's memory-request bus; it never drives memory.

## Interface
Parameters:
- `CHANNELS`, 2: number of caches; must be at least 1.
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data width.
- `FIFO_DEPTH`, 4: entries per channel queue; a power of 2, at least 2.
- Derived (localparam): `REQ_W = 1 + ADDR_W + DATA_W`. Request layout: [REQ_W-1] = write, then address, then data in the low bits.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cache_change`  in  CHANNELS*REQ_W  request bus per channel; channel i is at [i*REQ_W +: REQ_W].
- `cache_change_valid`  in  CHANNELS  request strobe per channel.
- `cache_invalidate`  out  CHANNELS*ADDR_W  invalidate address per channel; channel i is at [i*ADDR_W +: ADDR_W].
- `cache_invalidate_valid`  out  CHANNELS  invalidate pending toward channel i.
- `cache_invalidate_ack`  in  CHANNELS  channel i has accepted its invalidate.
- `queue_full`  out  CHANNELS  queue i holds FIFO_DEPTH entries.
- `overflow`  out  CHANNELS  sticky: a write was dropped on channel i.
- `busy`  out  1  a broadcast is in progress.

## Operation
- **Capture.** At each edge, for every channel i where `cache_change_valid[i]` is high and the write bit is set, push the address into queue i. Reads and data bits are ignored.
- **Full queue.** Fullness is judged on the count at the start of the cycle. A push to a full queue is dropped and sets `overflow[i]`, even if that queue pops in the same cycle. `overflow` clears only on reset.
- **States.** The controller has two states, IDLE and BCAST.
- **IDLE.** If any queue is non-empty, grant the first non-empty channel searching from `last_grant+1` upward, modulo CHANNELS. On the grant:
  - pop the head into `addr_q`;
  - set `pending` = all channels except the granted one;
  - set `last_grant` = granted channel;
  - go to BCAST.
- **BCAST.**
  - `cache_invalidate_valid` = `pending`.
  - Every channel's slice of `cache_invalidate` = `addr_q`.
  - At an edge where both `valid[j]` and `ack[j]` are high, clear `pending[j]`. Ack while valid is low is ignored.
  - When this edge clears the last pending bit and some queue is non-empty, grant the next channel at the same edge and stay in BCAST. Otherwise go to IDLE.
- **Single channel.** With CHANNELS=1 the pending mask is empty. Each grant pops and discards its entry, and the controller returns to IDLE at the same edge.
- **Outputs.**
  - `busy` = state is BCAST.
  - `queue_full[i]` = count[i] == FIFO_DEPTH.
- **Reset.** Reset is asynchronous and takes effect immediately, including mid-broadcast.
  - Queues are emptied, `pending` = 0, state = IDLE.
  - `last_grant` = CHANNELS-1, so channel 0 has first priority.
  - All outputs go to 0: `cache_invalidate` = 0, `cache_invalidate_valid` = 0, `overflow` = 0, `queue_full` = 0, `busy` = 0.
- **Queues.** Each queue is a circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap naturally, plus a separate count of log2(FIFO_DEPTH)+1 bits. Push and pop in the same cycle on a non-full, non-empty queue leave the count unchanged.

## Timing
- All outputs are registered.
- Write captured at edge k, queue previously empty, hub IDLE: `cache_invalidate_valid` rises after edge k+1.
- Targets ack in the same cycle as valid: valid drops after the next edge, or the next grant loads at that edge.
- Sustained throughput: one invalidation per cycle, provided all targets ack combinationally.
- Each target's valid is held until that target acks. Targets may ack in different cycles.
- `cache_invalidate` is stable for the whole broadcast. Between broadcasts it holds its last value.

## Test plan
- **Single write, CHANNELS=2.** Reset; channel 0 pushes write, address 0x1234. Required: after the next edge, `valid` = 2'b10 and channel 1's address = 0x1234. With ack[1] held high, `valid` = 0 one edge later; `busy` pulses for one cycle.
- **Reads ignored.** Channel 1 issues a read of 0xBEEF. Required: no push, `busy` stays 0.
- **Round-robin fairness.** Channels 0 and 1 write 0x0001 and 0x0002 in the same cycle, acks held high. Required: grants in order 0 then 1, on back-to-back edges.
- **Staggered acks, CHANNELS=4.** Channel 2 writes 0x00AA; ack[0] at cycle 3, ack[3] at cycle 5, ack[1] at cycle 6. Required: each valid bit drops individually after its ack; `busy` falls after the cycle-6 edge.
- **Overflow, FIFO_DEPTH=4.** Hold all acks low; channel 0 writes 6 times. Required: `queue_full[0]` set, `overflow[0]` = 1. After releasing acks, exactly 5 broadcasts occur: 1 in flight plus 4 queued.
- **Mid-broadcast reset.** Assert reset while `busy` = 1 and queues are non-empty. Required: all outputs 0 immediately; no broadcast after reset releases.
